pipe_stall_ctrl: RTL and testbench

//  Consumer of the Hazard_Detect stall request. Owns the PC and IF/ID pipeline registers.

---
 rtl/pipe_stall_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: owns the PC and the IF/ID register and turns the hazard
// stall request, branch redirects, instruction-memory waits and data-memory
// busy into PC/IF-ID updates plus the ID/EX bubble and pipe freeze controls.
//
// Optional feature: define PIPE_PERF_CNT_EN to add the perf_stall_cyc,
// perf_flush_cnt and perf_freeze_cyc counter outputs.
//
// Handshake: imem_ready is the valid qualifier for imem_instr at address pc.
// A fetch completes on a rising edge where imem_ready=1 and nothing of higher
// priority (mem_busy, stall, branch_taken) holds or redirects the front end;
// the fetch stage has no back-pressure beyond those controls.
module pipe_stall_ctrl #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned     MAX_STALL = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            mem_busy,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic            if_id_valid,
    output logic            id_ex_bubble,
    output logic            pipe_freeze,
    output logic            stall_timeout,
    output logic [1:0]      state_dbg
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cyc,
    output logic [31:0]     perf_flush_cnt,
    output logic [31:0]     perf_freeze_cyc
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Counter saturates one past MAX_STALL so "more than MAX_STALL" is visible.
    localparam int unsigned        CNT_W   = $clog2(MAX_STALL + 2);
    localparam logic [CNT_W-1:0]   CNT_LIM = CNT_W'(MAX_STALL);
    localparam logic [CNT_W-1:0]   CNT_SAT = CNT_W'(MAX_STALL + 1);

    state_t           state;
    logic [CNT_W-1:0] stall_cnt;
    logic             active;
    logic             take_branch;

    // Controls are only live once out of BOOT and not in reset.
    assign active       = (state != ST_BOOT) && !rst;
    assign pipe_freeze  = active && mem_busy;
    assign id_ex_bubble = active && !mem_busy && stall;
    assign take_branch  = active && !mem_busy && !stall && branch_taken;
    assign state_dbg    = state;

    // FSM plus PC / IF-ID update with mem_busy > stall > branch > imem wait > fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    // No fetch in the boot cycle: pc held, IF/ID stays invalid.
                    state <= ST_RUN;
                end
                default: begin
                    state <= (mem_busy || stall) ? ST_HOLD : ST_RUN;
                    if (mem_busy || stall) begin
                        // Front end holds; branch is re-resolved after the hold.
                    end else if (branch_taken) begin
                        pc          <= branch_target;
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                    end else if (!imem_ready) begin
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                    end else begin
                        pc          <= pc + XLEN'(4);
                        if_id_pc    <= pc;
                        if_id_instr <= imem_instr;
                        if_id_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Consecutive hazard-stall counter; mem_busy cycles neither count nor clear it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt     <= '0;
            stall_timeout <= 1'b0;
        end else if (!stall) begin
            stall_cnt <= '0;
        end else if (!mem_busy && (state != ST_BOOT)) begin
            if (stall_cnt != CNT_SAT) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (stall_cnt >= CNT_LIM) begin
                stall_timeout <= 1'b1;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cyc  <= '0;
            perf_flush_cnt  <= '0;
            perf_freeze_cyc <= '0;
        end else begin
            if (id_ex_bubble) perf_stall_cyc  <= perf_stall_cyc + 32'd1;
            if (take_branch)  perf_flush_cnt  <= perf_flush_cnt + 32'd1;
            if (pipe_freeze)  perf_freeze_cyc <= perf_freeze_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed vectors, a cycle model built from the
// priority rules, a per-cycle compare process and literal spot checks.
module tb_pipe_stall_ctrl;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam int          MAX_STALL = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, mem_busy, branch_taken, imem_ready;
    logic [31:0] branch_target, imem_instr;
    logic [31:0] pc, if_id_pc, if_id_instr;
    logic        if_id_valid, id_ex_bubble, pipe_freeze, stall_timeout;
    logic [1:0]  state_dbg;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_freeze_cyc;
    logic [31:0] m_perf_stall, m_perf_flush, m_perf_freeze;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;
    logic chk_en = 1'b0;

    // Model state
    logic [31:0] m_pc, m_if_pc, m_if_instr;
    logic        m_valid, m_boot, m_to;
    int          m_run;

    pipe_stall_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .mem_busy      (mem_busy),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_ready    (imem_ready),
        .imem_instr    (imem_instr),
        .pc            (pc),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .id_ex_bubble  (id_ex_bubble),
        .pipe_freeze   (pipe_freeze),
        .stall_timeout (stall_timeout),
        .state_dbg     (state_dbg)
`ifdef PIPE_PERF_CNT_EN
        ,
        .perf_stall_cyc  (perf_stall_cyc),
        .perf_flush_cnt  (perf_flush_cnt),
        .perf_freeze_cyc (perf_freeze_cyc)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: what each rising edge must do, straight from the priority list.
    always @(posedge clk) begin
        logic busy_now, live;
        live = !rst && !m_boot;
        busy_now = mem_busy;
`ifdef PIPE_PERF_CNT_EN
        if (!rst) begin
            if (live && stall && !busy_now) m_perf_stall++;
            if (live && busy_now) m_perf_freeze++;
            if (live && !busy_now && !stall && branch_taken) m_perf_flush++;
        end
`endif
        if (rst) begin
            m_pc = 32'h0; m_if_pc = 32'h0; m_if_instr = NOP; m_valid = 1'b0;
            m_boot = 1'b1; m_run = 0; m_to = 1'b0;
`ifdef PIPE_PERF_CNT_EN
            m_perf_stall = 0; m_perf_flush = 0; m_perf_freeze = 0;
`endif
        end else begin
            if (!stall) m_run = 0;
            else if (live && !busy_now) m_run++;
            if (m_run > MAX_STALL) m_to = 1'b1;
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (busy_now || stall) begin
                // hold
            end else if (branch_taken) begin
                m_pc = branch_target; m_if_instr = NOP; m_valid = 1'b0;
            end else if (!imem_ready) begin
                m_if_instr = NOP; m_valid = 1'b0;
            end else begin
                m_if_pc = m_pc; m_if_instr = imem_instr; m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end
    end

    // Compare process: every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            #2;
            check("pc", pc, m_pc);
            check("if_id_valid", 32'(if_id_valid), 32'(m_valid));
            check("if_id_instr", if_id_instr, m_if_instr);
            if (m_valid) check("if_id_pc", if_id_pc, m_if_pc);
            check("id_ex_bubble", 32'(id_ex_bubble), 32'(!rst && !m_boot && stall && !mem_busy));
            check("pipe_freeze", 32'(pipe_freeze), 32'(!rst && !m_boot && mem_busy));
            check("stall_timeout", 32'(stall_timeout), 32'(m_to));
`ifdef PIPE_PERF_CNT_EN
            check("perf_stall_cyc", perf_stall_cyc, m_perf_stall);
            check("perf_flush_cnt", perf_flush_cnt, m_perf_flush);
            check("perf_freeze_cyc", perf_freeze_cyc, m_perf_freeze);
`endif
        end
    end

    // Driver tasks: inputs change on the falling edge only.
    task automatic set_in(input logic s, input logic b, input logic br,
                          input logic [31:0] tgt, input logic rdy);
        stall = s; mem_busy = b; branch_taken = br; branch_target = tgt;
        imem_ready = rdy; imem_instr = 32'hC0DE_0000 | 32'(cyc_n);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc_n++;
        imem_instr = 32'hC0DE_0000 | 32'(cyc_n);
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 32'h0, 0);
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_in(0, 0, 0, 32'h0, 1);
        #1 check("lit_boot_pc", pc, 32'h0);
        check("lit_boot_valid", 32'(if_id_valid), 32'h0);
        check("lit_boot_instr", if_id_instr, NOP);
        check("lit_boot_bubble", 32'(id_ex_bubble), 32'h0);

        // 1: boot cycle then sequential fetch
        tick(); #1 check("lit_run_pc0", pc, 32'h0);
        check("lit_run_valid0", 32'(if_id_valid), 32'h0);
        tick(); #1 check("lit_fetch_pc4", pc, 32'h4);
        check("lit_fetch_valid", 32'(if_id_valid), 32'h1);
        check("lit_fetch_ifpc", if_id_pc, 32'h0);
        tick(); #1 check("lit_fetch_pc8", pc, 32'h8);
        tick(); tick(); #1 check("lit_pc10", pc, 32'h10);

        // 2: two-cycle stall at 0x10
        set_in(1, 0, 0, 32'h0, 1);
        #1 check("lit_stall_bubble", 32'(id_ex_bubble), 32'h1);
        tick(); #1 check("lit_stall_pc_a", pc, 32'h10);
        tick(); #1 check("lit_stall_pc_b", pc, 32'h10);
        set_in(0, 0, 0, 32'h0, 1);
        tick(); #1 check("lit_resume_pc", pc, 32'h14);
        check("lit_resume_ifpc", if_id_pc, 32'h10);

        // 3: taken branch
        set_in(0, 0, 1, 32'h200, 1);
        tick(); #1 check("lit_br_pc", pc, 32'h200);
        check("lit_br_valid", 32'(if_id_valid), 32'h0);
        check("lit_br_instr", if_id_instr, NOP);
        set_in(0, 0, 0, 32'h0, 1);
        tick(); #1 check("lit_after_br_pc", pc, 32'h204);

        // 4: stall beats branch; branch lands the next cycle
        set_in(1, 0, 1, 32'h400, 1);
        tick(); #1 check("lit_stall_br_pc", pc, 32'h204);
        set_in(0, 0, 1, 32'h400, 1);
        tick(); #1 check("lit_rebr_pc", pc, 32'h400);

        // instruction-memory wait
        set_in(0, 0, 0, 32'h0, 0);
        tick(); #1 check("lit_imem_wait_pc", pc, 32'h400);
        check("lit_imem_wait_valid", 32'(if_id_valid), 32'h0);
        set_in(0, 0, 0, 32'h0, 1);
        tick(); #1 check("lit_imem_go_pc", pc, 32'h404);

        // 5: mem_busy with stall, then release into the stall path
        set_in(1, 1, 1, 32'h800, 1);
        #1 check("lit_frz", 32'(pipe_freeze), 32'h1);
        check("lit_frz_bubble", 32'(id_ex_bubble), 32'h0);
        tick(); #1 check("lit_frz_pc", pc, 32'h404);
        set_in(1, 0, 0, 32'h0, 1);
        #1 check("lit_unfrz_bubble", 32'(id_ex_bubble), 32'h1);
        check("lit_unfrz_freeze", 32'(pipe_freeze), 32'h0);
        tick(); #1 check("lit_unfrz_pc", pc, 32'h404);
        set_in(0, 0, 0, 32'h0, 1);
        tick(); #1 check("lit_go_pc", pc, 32'h408);

        // PC wrap at 2^32
        set_in(0, 0, 1, 32'hFFFF_FFFC, 1);
        tick();
        set_in(0, 0, 0, 32'h0, 1);
        tick(); #1 check("lit_wrap_pc", pc, 32'h0);
        check("lit_wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);

        // Stall run broken by one free cycle never times out
        set_in(1, 0, 0, 32'h0, 1);
        repeat (10) tick();
        set_in(0, 0, 0, 32'h0, 1);
        tick();
        set_in(1, 0, 0, 32'h0, 1);
        repeat (10) tick();
        #1 check("lit_no_timeout", 32'(stall_timeout), 32'h0);

        // 6: 17-cycle stall; timeout on the 16th, sticky afterwards
        set_in(0, 0, 0, 32'h0, 1);
        tick();
        set_in(1, 0, 0, 32'h0, 1);
        repeat (15) tick();
        #1 check("lit_to_15", 32'(stall_timeout), 32'h0);
        tick(); #1 check("lit_to_16", 32'(stall_timeout), 32'h1);
        tick();
        set_in(0, 0, 0, 32'h0, 1);
        tick(); tick(); #1 check("lit_to_sticky", 32'(stall_timeout), 32'h1);

        // Reset during a stalled redirect: reset values win
        set_in(1, 0, 1, 32'h900, 1);
        rst = 1'b1;
        #1 check("lit_rst_bubble", 32'(id_ex_bubble), 32'h0);
        tick(); #1 check("lit_rst_pc", pc, 32'h0);
        check("lit_rst_to", 32'(stall_timeout), 32'h0);
        check("lit_rst_valid", 32'(if_id_valid), 32'h0);
        rst = 1'b0;
        set_in(0, 0, 0, 32'h0, 1);
        tick(); #1 check("lit_reboot_pc", pc, 32'h0);
        tick(); #1 check("lit_reboot_pc4", pc, 32'h4);

        // mem_busy cycles inside a stall run neither count nor clear
        set_in(1, 0, 0, 32'h0, 1);
        repeat (10) tick();
        set_in(1, 1, 0, 32'h0, 1);
        repeat (5) tick();
        set_in(1, 0, 0, 32'h0, 1);
        repeat (5) tick();
        #1 check("lit_busy_to_15", 32'(stall_timeout), 32'h0);
        tick(); #1 check("lit_busy_to_16", 32'(stall_timeout), 32'h1);
        set_in(0, 0, 0, 32'h0, 1);
        tick(); tick();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
